tlp128_axis_tx: RTL



---
 rtl/tlp128_axis_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tlp128_axis_tx.sv
// ============================================================================
// Module   : tlp128_axis_tx
// Brief    : Serialises one buffered packed TLP into 64-bit AXI-stream beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlp128_axis_tx #(
  parameter int NUM_QW         = 18,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [66*NUM_QW-1:0] tlp_data,
  input  logic                 tlp_valid,
  input  logic                 tlp_has_data,
  output logic                 tlp_req_data,
  output logic [63:0]          tx_data,
  output logic [7:0]           tx_keep,
  output logic                 tx_last,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [15:0]          tlp_count,
  output logic                 timeout_pulse
);

  localparam int IDX_W = (NUM_QW > 1) ? $clog2(NUM_QW) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_QW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [66*NUM_QW-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [63:0]          tx_data_q, tx_data_d;
  logic [7:0]           tx_keep_q, tx_keep_d;
  logic                 tx_last_q, tx_last_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [15:0]          tlp_count_q, tlp_count_d;
  logic                 timeout_q, timeout_d;

  logic [65:0]          slots [NUM_QW];
  logic [IDX_W-1:0]     idx_nxt;
  logic                 beat_done;

  for (genvar i = 0; i < NUM_QW; i++) begin : g_slot
    assign slots[i] = buf_q[66*i +: 66];
  end

  assign idx_nxt   = idx_q + IDX_W'(1);
  assign beat_done = tx_valid_q & tx_ready;

  // {last, keep, data}; the index cap forces last on frames missing a last flag
  function automatic logic [72:0] mk_beat(input logic [65:0] s, input logic [IDX_W-1:0] i);
    logic       last;
    logic [7:0] keep;
    last = s[64] | (i == LAST_IDX);
    keep = (last && !s[65]) ? 8'h0F : 8'hFF;
    return {last, keep, s[63:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tlp_has_data) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (tlp_valid)           state_d = S_SEND;
        else if (cnt_q == CNT_MAX) state_d = S_IDLE;
      end
      S_SEND:  if (beat_done && tx_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tlp_req_data = (state_q == S_REQ);
  end

  always_comb begin
    buf_d       = buf_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_keep_d   = tx_keep_q;
    tx_last_d   = tx_last_q;
    tx_valid_d  = tx_valid_q;
    tlp_count_d = tlp_count_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (tlp_valid) begin
          buf_d      = tlp_data;
          idx_d      = '0;
          cnt_d      = '0;
          {tx_last_d, tx_keep_d, tx_data_d} = mk_beat(tlp_data[65:0], '0);
          tx_valid_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (beat_done) begin
          if (tx_last_q) begin
            tx_valid_d  = 1'b0;
            tx_last_d   = 1'b0;
            tx_keep_d   = 8'h00;
            tlp_count_d = tlp_count_q + 16'd1;
          end else begin
            idx_d = idx_nxt;
            {tx_last_d, tx_keep_d, tx_data_d} = mk_beat(slots[idx_nxt], idx_nxt);
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_keep_q   <= '0;
      tx_last_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tlp_count_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_keep_q   <= tx_keep_d;
      tx_last_q   <= tx_last_d;
      tx_valid_q  <= tx_valid_d;
      tlp_count_q <= tlp_count_d;
      timeout_q   <= timeout_d;
    end
  end

  // Frame buffer is only ever read after a fresh capture, so it needs no reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign tx_data       = tx_data_q;
  assign tx_keep       = tx_keep_q;
  assign tx_last       = tx_last_q;
  assign tx_valid      = tx_valid_q;
  assign tlp_count     = tlp_count_q;
  assign timeout_pulse = timeout_q;

endmodule

`default_nettype wire
